spram_generic_wbe_pipe: RTL and testbench
=========================================

// Module: spram_generic_wbe_pipe
// PURPOSE
//  Parametrised single-port SRAM model with per-byte write enables, a selectable
//  read-during-write mode, an optional output register stage and a read-valid strobe.
//  An optional post-reset sweep writes INIT_VAL to every word; init_busy is high until
//  the sweep finishes. Used as the generic on-chip RAM behind AHB slave wrappers.
// PARAMETERS
//  ADDR_BITS    7      address width
//  ADDR_AMOUNT  128    number of words, 1..2**ADDR_BITS
//  DATA_BITS    32     word width; must be a multiple of 8
//  BE_BITS      DATA_BITS/8  byte-lane count (derived; not overridden)
//  OUT_REG      0      0: read latency 1; 1: extra output register, latency 2
//  RDW_MODE     0      on write: 0 no-change (dout holds), 1 write-first, 2 read-first
//  INIT_EN      1      1: run clear sweep after reset; 0: no sweep, contents undefined
//  INIT_VAL     0      DATA_BITS value written by the sweep
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous active-high reset
//  en         in   1            access request, sampled each cycle
//  we         in   1            1 write, 0 read (qualified by en)
//  wbe        in   BE_BITS      byte write enables, bit i -> din[8i+7:8i]
//  addr       in   ADDR_BITS    word address
//  din        in   DATA_BITS    write data
//  dout       out  DATA_BITS    read data, held between reads
//  dout_vld   out  1            one-cycle strobe, dout updated this cycle
//  init_busy  out  1            sweep in progress; accesses ignored
// BEHAVIOUR
//  Reset (rst=1 at edge): dout=0, dout_vld=0, output pipe cleared, sweep ptr=0;
//   init_busy=1 if INIT_EN else 0. Memory array itself is not reset by rst.
//  Sweep FSM: INIT -> READY. INIT entered on rst when INIT_EN=1. Each INIT cycle
//   (rst=0) writes INIT_VAL to mem[ptr], ptr++; after writing ADDR_AMOUNT-1, goes to
//   READY. init_busy=1 in INIT, so it drops exactly ADDR_AMOUNT cycles after rst falls.
//   rst during INIT restarts sweep at ptr 0. INIT_EN=0: FSM resets directly to READY.
//  Accept: access accepted at edge when en=1, init_busy=0, rst=0. Otherwise ignored.
//  Write: for each i with wbe[i]=1, mem[addr] byte i <= din byte i; others keep.
//   wbe=0 with we=1 is a legal no-op write (no memory change).
//  Read: accepted read at edge N -> stage-1 data = mem[addr] (old contents).
//   OUT_REG=0: dout/dout_vld update at edge N (visible cycle N+1). OUT_REG=1: one
//   further register, visible cycle N+2. Back-to-back reads give one result per cycle.
//  Write result on dout per RDW_MODE: 0 no dout update, dout_vld=0; 1 dout = merged
//   word (new bytes where wbe=1, old elsewhere), dout_vld=1; 2 dout = old word,
//   dout_vld=1. Latency same as a read.
//  dout holds its last value whenever dout_vld=0.
//  addr >= ADDR_AMOUNT: write dropped; read returns 0 with dout_vld=1.
//  rst mid-pipeline: in-flight read results discarded, no dout_vld after reset.
//  Single port: one access per cycle, no internal arbitration or queueing.
// TESTING
//  T1 INIT_EN=1, ADDR_AMOUNT=128: rst 1 cycle -> init_busy high exactly 128 cycles;
//     then read all addrs -> every word == INIT_VAL.
//  T2 OUT_REG=0: write 0xA5A5A5A5 addr 5 wbe=4'hF; read addr 5 at edge N -> dout=
//     0xA5A5A5A5, dout_vld=1 in cycle N+1 only; OUT_REG=1 same but N+2.
//  T3 Byte lanes: addr 3 = 0x11223344; write din=0xAABBCCDD wbe=4'b0101 -> read
//     gives 0x11BB33DD.
//  T4 RDW_MODE sweep on same write as T3: mode0 dout unchanged, vld=0; mode1 dout=
//     0x11BB33DD; mode2 dout=0x11223344, vld=1.
//  T5 rst asserted at sweep ptr=60 -> ptr restarts, init_busy stays high 128 more
//     cycles; en=1 during busy -> no write, no dout_vld.
//  T6 Back-to-back reads addr 0,1,2 with OUT_REG=1, then rst on the cycle after the
//     last read -> only results for 0 and 1 appear (dout_vld 2 cycles), none after rst.

Source files
------------

// File: rtl/spram_generic_wbe_pipe.sv
// Generic single-port SRAM model with per-byte write enables, selectable read-during-write
// result, optional output register and an optional post-reset fill sweep.
module spram_generic_wbe_pipe #(
    parameter int                   ADDR_BITS   = 7,
    parameter int                   ADDR_AMOUNT = 128,
    parameter int                   DATA_BITS   = 32,
    localparam int                  BE_BITS     = DATA_BITS / 8,
    parameter int                   OUT_REG     = 0,
    parameter int                   RDW_MODE    = 0,
    parameter int                   INIT_EN     = 1,
    parameter logic [DATA_BITS-1:0] INIT_VAL    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 we,
    input  logic [BE_BITS-1:0]   wbe,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    output logic                 init_busy
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ADDR_AMOUNT - 1);
    localparam logic [ADDR_BITS:0]   DEPTH     = (ADDR_BITS + 1)'(ADDR_AMOUNT);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                 sweep_wr;

    logic [DATA_BITS-1:0] mem [ADDR_AMOUNT];

    logic                 acc;
    logic                 in_range;
    logic [DATA_BITS-1:0] old_word;
    logic [DATA_BITS-1:0] merged_word;
    logic                 res_vld;
    logic [DATA_BITS-1:0] res_data;
    logic                 s1_vld;
    logic [DATA_BITS-1:0] s1_data;

    // Sweep FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_EN != 0) ? ST_INIT : ST_READY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep FSM: next state, pointer and fill-write strobe
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                sweep_wr = 1'b1;
                ptr_d    = ptr_q + ADDR_BITS'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == ST_INIT);

    // en is a one-cycle request with no back-pressure; it is taken only while not busy.
    // dout_vld pulses for exactly one cycle whenever dout carries a new result.
    assign acc      = en && !init_busy;
    assign in_range = {1'b0, addr} < DEPTH;
    assign old_word = in_range ? mem[addr] : '0;

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < BE_BITS; i++) begin
            if (wbe[i]) merged_word[8*i +: 8] = din[8*i +: 8];
        end
    end

    // Result of the accepted access as it would appear on dout
    always_comb begin
        res_vld  = 1'b0;
        res_data = old_word;
        if (acc) begin
            if (!we) begin
                res_vld = 1'b1;
            end else if (RDW_MODE == 1) begin
                res_vld  = 1'b1;
                res_data = in_range ? merged_word : '0;
            end else if (RDW_MODE == 2) begin
                res_vld = 1'b1;
            end
        end
    end

    // Array is deliberately not reset; only the sweep or accepted writes change it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_wr) begin
                mem[ptr_q] <= INIT_VAL;
            end else if (acc && we && in_range) begin
                for (int i = 0; i < BE_BITS; i++) begin
                    if (wbe[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld <= res_vld;
            if (res_vld) s1_data <= res_data;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout     <= '0;
                    dout_vld <= 1'b0;
                end else begin
                    dout_vld <= s1_vld;
                    if (s1_vld) dout <= s1_data;
                end
            end
        end else begin : g_noreg
            assign dout     = s1_data;
            assign dout_vld = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_spram_generic_wbe_pipe.sv
// Bench for spram_generic_wbe_pipe: three instances sharing one stimulus stream, each with a
// different output latency / read-during-write mode, checked against an array-based model.
module tb_spram_generic_wbe_pipe;

    localparam int          AB = 8;
    localparam int          AA = 128;
    localparam int          ND = 3;
    localparam logic [31:0] IV = 32'h5A5A_0F0F;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  wbe;
    logic [AB-1:0] addr;
    logic [31:0] din;
    logic [31:0] dout_a [ND];
    logic        vld_a  [ND];
    logic        busy_a [ND];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] mdl_mem [AA];
    int          busy_cnt = 0;
    logic        exp_vld   [ND];
    logic [31:0] exp_dout  [ND];
    logic        pend_vld  [ND];
    logic [31:0] pend_data [ND];

    // dut k: read-during-write mode k; dut 1 also has the output register
    spram_generic_wbe_pipe #(.ADDR_BITS(AB), .ADDR_AMOUNT(AA), .DATA_BITS(32), .OUT_REG(0),
        .RDW_MODE(0), .INIT_EN(1), .INIT_VAL(IV)) d0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .wbe(wbe), .addr(addr), .din(din),
        .dout(dout_a[0]), .dout_vld(vld_a[0]), .init_busy(busy_a[0]));
    spram_generic_wbe_pipe #(.ADDR_BITS(AB), .ADDR_AMOUNT(AA), .DATA_BITS(32), .OUT_REG(1),
        .RDW_MODE(1), .INIT_EN(1), .INIT_VAL(IV)) d1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .wbe(wbe), .addr(addr), .din(din),
        .dout(dout_a[1]), .dout_vld(vld_a[1]), .init_busy(busy_a[1]));
    spram_generic_wbe_pipe #(.ADDR_BITS(AB), .ADDR_AMOUNT(AA), .DATA_BITS(32), .OUT_REG(0),
        .RDW_MODE(2), .INIT_EN(1), .INIT_VAL(IV)) d2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .wbe(wbe), .addr(addr), .din(din),
        .dout(dout_a[2]), .dout_vld(vld_a[2]), .init_busy(busy_a[2]));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model of one clock edge, using the inputs as sampled at that edge
    task automatic model_step();
        logic        acc, inr, rv;
        logic [31:0] old, merged, rd;
        if (rst) begin
            busy_cnt = AA;
            for (int k = 0; k < ND; k++) begin
                exp_vld[k]   = 1'b0;
                exp_dout[k]  = 32'h0;
                pend_vld[k]  = 1'b0;
                pend_data[k] = 32'h0;
            end
        end else begin
            acc    = en && (busy_cnt == 0);
            inr    = (int'(addr) < AA);
            old    = inr ? mdl_mem[addr[6:0]] : 32'h0;
            merged = old;
            for (int i = 0; i < 4; i++) if (wbe[i]) merged[8*i +: 8] = din[8*i +: 8];
            if (busy_cnt > 0) begin
                mdl_mem[AA - busy_cnt] = IV;
                busy_cnt = busy_cnt - 1;
            end else if (acc && we && inr) begin
                mdl_mem[addr[6:0]] = merged;
            end
            for (int k = 0; k < ND; k++) begin
                rv = 1'b0;
                rd = old;
                if (acc && !we) rv = 1'b1;
                else if (acc && we && k == 1) begin
                    rv = 1'b1;
                    rd = inr ? merged : 32'h0;
                end else if (acc && we && k == 2) rv = 1'b1;
                if (k == 1) begin
                    exp_vld[k] = pend_vld[k];
                    if (pend_vld[k]) exp_dout[k] = pend_data[k];
                    pend_vld[k]  = rv;
                    pend_data[k] = rd;
                end else begin
                    exp_vld[k] = rv;
                    if (rv) exp_dout[k] = rd;
                end
            end
        end
    endtask

    // Driver: advance one edge; outputs are sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int n;
        en = 0; we = 0; wbe = 0; addr = 0; din = 0; rst = 1;
        tick();
        tick();
        rst = 0;
        for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (dout_a[k] !== 32'h0 || vld_a[k] !== 1'b0 || busy_a[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: dout=%h vld=%b busy=%b, required 0/0/1",
                         k, dout_a[k], vld_a[k], busy_a[k]);
            end
        end
        n = 0;
        for (int c = 0; c < 300 && busy_a[0] === 1'b1; c++) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != AA) begin
            n_fail++;
            $display("FAIL busy_length: busy for %0d cycles, required %0d", n, AA);
        end
        for (int k = 0; k < ND; k++) begin
            n_checks++;
            if (busy_a[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_done dut%0d: busy=%b, required 0", k, busy_a[k]);
            end
        end
    endtask

    task automatic test_init_contents();
        for (int a = 0; a < AA + 2; a++) begin
            en = (a < AA); we = 0; wbe = 0; addr = AB'(a % AA); din = 0;
            tick();
            if (a < AA) begin
                n_checks++;
                if (vld_a[0] !== 1'b1 || dout_a[0] !== IV) begin
                    n_fail++;
                    $display("FAIL init_word addr %0d: vld=%b dout=%h, required 1/%h",
                             a, vld_a[0], dout_a[0], IV);
                end
            end
            for (int k = 0; k < ND; k++) begin
                n_checks++;
                if (vld_a[k] !== exp_vld[k] || dout_a[k] !== exp_dout[k]) begin
                    n_fail++;
                    $display("FAIL init_model dut%0d step %0d: vld=%b dout=%h, required %b/%h",
                             k, a, vld_a[k], dout_a[k], exp_vld[k], exp_dout[k]);
                end
            end
        end
        en = 0;
    endtask

    task automatic test_write_read();
        en = 1; we = 1; wbe = 4'hF; addr = 5; din = 32'hA5A5_A5A5;
        tick();
        en = 0; we = 0;
        tick();
        en = 1; we = 0; addr = 5;
        tick();
        en = 0;
        for (int k = 0; k < ND; k += 2) begin
            n_checks++;
            if (vld_a[k] !== 1'b1 || dout_a[k] !== 32'hA5A5_A5A5) begin
                n_fail++;
                $display("FAIL wr_rd_lat1 dut%0d: vld=%b dout=%h, required 1/a5a5a5a5",
                         k, vld_a[k], dout_a[k]);
            end
        end
        n_checks++;
        if (vld_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_lat2_early: vld=%b, required 0", vld_a[1]);
        end
        tick();
        n_checks++;
        if (vld_a[0] !== 1'b0 || dout_a[0] !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL wr_rd_hold: vld=%b dout=%h, required 0/a5a5a5a5", vld_a[0], dout_a[0]);
        end
        n_checks++;
        if (vld_a[1] !== 1'b1 || dout_a[1] !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL wr_rd_lat2: vld=%b dout=%h, required 1/a5a5a5a5", vld_a[1], dout_a[1]);
        end
        tick();
        n_checks++;
        if (vld_a[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rd_lat2_strobe: vld=%b, required 0", vld_a[1]);
        end
    endtask

    task automatic test_byte_lanes();
        en = 1; we = 1; wbe = 4'hF; addr = 3; din = 32'h1122_3344;
        tick();
        en = 0;
        tick();
        tick();
        en = 1; we = 1; wbe = 4'b0101; addr = 3; din = 32'hAABB_CCDD;
        tick();
        en = 0; we = 0;
        n_checks++;
        if (vld_a[0] !== 1'b0 || dout_a[0] !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL rdw_mode0: vld=%b dout=%h, required 0/a5a5a5a5", vld_a[0], dout_a[0]);
        end
        n_checks++;
        if (vld_a[2] !== 1'b1 || dout_a[2] !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL rdw_mode2: vld=%b dout=%h, required 1/11223344", vld_a[2], dout_a[2]);
        end
        tick();
        n_checks++;
        if (vld_a[1] !== 1'b1 || dout_a[1] !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL rdw_mode1: vld=%b dout=%h, required 1/11bb33dd", vld_a[1], dout_a[1]);
        end
        en = 1; we = 0; addr = 3;
        tick();
        en = 0;
        n_checks++;
        if (vld_a[0] !== 1'b1 || dout_a[0] !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL byte_merge: vld=%b dout=%h, required 1/11bb33dd", vld_a[0], dout_a[0]);
        end
        tick();
        tick();
    endtask

    task automatic test_busy_restart();
        int n;
        rst = 1;
        tick();
        rst = 0; en = 0;
        for (int c = 0; c < 60; c++) tick();
        n_checks++;
        if (busy_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_busy: busy=%b, required 1", busy_a[0]);
        end
        rst = 1; en = 1; we = 0; addr = 0;
        tick();
        rst = 0;
        n = 0;
        for (int c = 0; c < 300 && busy_a[0] === 1'b1; c++) begin
            n++;
            en = 1; we = c[0]; wbe = 4'hF; addr = AB'(c % 10); din = $urandom;
            tick();
            for (int k = 0; k < ND; k++) begin
                n_checks++;
                if (vld_a[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_access dut%0d cycle %0d: vld=%b, required 0", k, c, vld_a[k]);
                end
            end
        end
        n_checks++;
        if (n != AA) begin
            n_fail++;
            $display("FAIL restart_length: busy for %0d cycles, required %0d", n, AA);
        end
        for (int a = 0; a < 10; a++) begin
            en = 1; we = 0; addr = AB'(a);
            tick();
            n_checks++;
            if (vld_a[0] !== 1'b1 || dout_a[0] !== IV) begin
                n_fail++;
                $display("FAIL busy_write_ignored addr %0d: vld=%b dout=%h, required 1/%h",
                         a, vld_a[0], dout_a[0], IV);
            end
        end
        en = 0;
        tick();
        tick();
    endtask

    task automatic test_rst_pipeline();
        logic [31:0] w [3];
        int nv;
        w[0] = 32'h1111_0000; w[1] = 32'h2222_0001; w[2] = 32'h3333_0002;
        for (int a = 0; a < 3; a++) begin
            en = 1; we = 1; wbe = 4'hF; addr = AB'(a); din = w[a];
            tick();
        end
        en = 0; we = 0;
        tick();
        tick();
        nv = 0;
        for (int c = 0; c < 9; c++) begin
            en = (c < 3); we = 0; addr = AB'(c);
            rst = (c == 3);
            tick();
            if (vld_a[1] === 1'b1) begin
                n_checks++;
                if (nv > 1 || dout_a[1] !== w[nv]) begin
                    n_fail++;
                    $display("FAIL pipe_data result %0d: dout=%h", nv, dout_a[1]);
                end
                nv++;
            end
        end
        rst = 0;
        n_checks++;
        if (nv != 2) begin
            n_fail++;
            $display("FAIL pipe_rst_count: %0d strobes, required 2", nv);
        end
        n_checks++;
        if (dout_a[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL pipe_rst_dout: dout=%h, required 0", dout_a[1]);
        end
        for (int c = 0; c < 300 && busy_a[0] === 1'b1; c++) tick();
        n_checks++;
        if (busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_sweep_timeout: busy still %b", busy_a[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            wbe  = 4'($urandom);
            addr = ($urandom_range(0, 3) == 0) ? AB'($urandom_range(128, 255))
                                               : AB'($urandom_range(0, 15));
            din  = $urandom;
            tick();
            for (int k = 0; k < ND; k++) begin
                n_checks++;
                if (vld_a[k] !== exp_vld[k] || dout_a[k] !== exp_dout[k] ||
                    busy_a[k] !== (busy_cnt != 0)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cycle %0d: vld=%b dout=%h busy=%b, required %b/%h/%b",
                             k, c, vld_a[k], dout_a[k], busy_a[k], exp_vld[k], exp_dout[k],
                             (busy_cnt != 0));
                end
            end
        end
        rst = 0; en = 0;
    endtask

    initial begin
        rst = 1; en = 0; we = 0; wbe = 0; addr = 0; din = 0;
        test_reset();
        test_init_contents();
        test_write_read();
        test_byte_lanes();
        test_busy_restart();
        test_rst_pipeline();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
